// File: rtl/piso_pkg.sv
// Shared definitions for the piso_33bit serial transmitter.
//   state_t       : frame FSM states (IDLE waits for a word, SHIFT drives bits)
//   DEFAULT_WIDTH : default word width of the 33-bit link
//   cw_of()       : width of a counter that must reach the value `width`
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 33;

  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dff_sr.sv
// Generic W-bit register with synchronous active-high reset to zero and a
// load enable. Used for every piece of state in piso_33bit.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-high, clears q to 0
//   en  : load enable; q takes d on a clock edge when high
//   d   : next value
//   q   : registered value
module dff_sr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/piso_33bit.sv
// Parallel-in / serial-out transmitter for the 33-bit serial link.
// A word is accepted through a valid/ready handshake while idle, then sent
// LSB-first on s_out, advancing one bit per cycle in which shift is high.
// A one-cycle done pulse follows the final shift edge.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous reset, active-high (aborts any frame, no done)
//   load_valid : p_in holds a word to send
//   load_ready : high only while idle; a load happens when valid && ready
//   p_in       : parallel word, sampled only on the load handshake
//   shift      : bit strobe shared with the receiver
//   s_out      : current serial bit (0 while idle)
//   busy       : frame in progress
//   done       : one-cycle pulse after the last bit has been shifted
//   count      : bits already shifted in the current frame
module piso_33bit
  import piso_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] p_in,
  input  logic             shift,
  output logic             s_out,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    count_d;
  logic [0:0]       state_q;
  logic [0:0]       state_d;
  state_t           state;

  logic load_fire;
  logic shift_fire;
  logic last_fire;
  logic data_en;
  logic state_en;

  assign state = state_t'(state_q);

  // Handshake and strobe qualification. Shift while idle and load while
  // shifting are both ignored by construction.
  assign load_fire  = (state == IDLE)  && load_valid;
  assign shift_fire = (state == SHIFT) && shift;
  assign last_fire  = shift_fire && (count == CW'(WIDTH - 1));

  // shreg and count change together: either a fresh load or one bit out.
  // On the last bit count naturally lands on WIDTH and holds there in IDLE.
  assign data_en  = load_fire || shift_fire;
  assign shreg_d  = load_fire ? p_in : (shreg >> 1);
  assign count_d  = load_fire ? '0 : (count + CW'(1));

  assign state_en = load_fire || last_fire;
  assign state_d  = load_fire ? SHIFT : IDLE;

  dff_sr #(.W(WIDTH)) u_shreg (
    .clk (clk),
    .rst (rst),
    .en  (data_en),
    .d   (shreg_d),
    .q   (shreg)
  );

  dff_sr #(.W(CW)) u_count (
    .clk (clk),
    .rst (rst),
    .en  (data_en),
    .d   (count_d),
    .q   (count)
  );

  dff_sr #(.W(1)) u_state (
    .clk (clk),
    .rst (rst),
    .en  (state_en),
    .d   (state_d),
    .q   (state_q)
  );

  // done is reloaded every cycle, so it is high for exactly the cycle after
  // the final shift edge.
  dff_sr #(.W(1)) u_done (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (last_fire),
    .q   (done)
  );

  // Outputs decode registers only; no input reaches an output combinationally.
  assign busy       = (state == SHIFT);
  assign load_ready = (state == IDLE);
  assign s_out      = busy && shreg[0];

endmodule

// File: tb/tb_piso_33bit.sv
// Testbench for piso_33bit: behavioural transmitter model plus a
// behavioural receiver that rebuilds each frame from s_out.
module tb_piso_33bit;

  localparam int W   = 33;
  localparam int CWB = $clog2(W + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load_valid = 1'b0;
  logic           load_ready;
  logic [W-1:0]   p_in = '0;
  logic           shift = 1'b0;
  logic           s_out;
  logic           busy;
  logic           done;
  logic [CWB-1:0] count;

  int vectors    = 0;
  int miscompares = 0;

  piso_33bit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .p_in       (p_in),
    .shift      (shift),
    .s_out      (s_out),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The word is kept whole; the bit on the wire is word[bits_sent].
  logic         started = 1'b0;
  logic         m_busy  = 1'b0;
  int           m_count = 0;
  logic         m_done  = 1'b0;
  logic [W-1:0] m_word  = '0;
  logic [W-1:0] rx      = '0;
  logic [W-1:0] rx_last = '0;
  int           frames  = 0;
  logic         s_neg   = 1'b0;
  int           done_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      started <= 1'b1;
      m_busy  <= 1'b0;
      m_count <= 0;
      m_done  <= 1'b0;
      m_word  <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && load_valid) begin
        m_word  <= p_in;
        m_count <= 0;
        m_busy  <= 1'b1;
        rx      <= '0;
      end else if (m_busy && shift) begin
        // receiver samples the bit present during the cycle before the edge
        rx[m_count] <= s_neg;
        m_count     <= m_count + 1;
        if (m_count == W - 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          rx_last <= rx | (W'(s_neg) << m_count);
          frames  <= frames + 1;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    s_neg <= s_out;
    if (done) done_cnt <= done_cnt + 1;
    if (started) begin
      chk("s_out", 64'(s_out), 64'(m_busy ? m_word[m_count] : 1'b0));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("load_ready", 64'(load_ready), 64'(!m_busy));
      chk("count", 64'(count), 64'(m_count));
      chk("done", 64'(done), 64'(m_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] w);
    p_in       = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (frames < n && k < budget) begin
      step();
      k++;
    end
    if (frames < n) chk({name, "_timeout"}, 64'(frames), 64'(n));
  endtask

  int f0, d0, lat;

  initial begin
    // ---- reset then idle ----
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_out", 64'(s_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(load_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    step();
    shift = 1'b1;
    repeat (3) step();
    shift = 1'b0;
    @(negedge clk);
    chk("idle_shift_count", 64'(count), 64'd0);
    step();

    // ---- loopback, continuous shift ----
    d0 = done_cnt;
    f0 = frames;
    do_load(33'h1_2345_6789);
    shift = 1'b1;
    repeat (33) step();
    shift = 1'b0;
    @(negedge clk);
    chk("loop_done", 64'(done), 64'd1);
    chk("loop_ready", 64'(load_ready), 64'd1);
    chk("loop_count", 64'(count), 64'd33);
    chk("loop_rx", 64'(rx_last), 64'h1_2345_6789);
    step();
    step();
    chk("loop_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("loop_frames", 64'(frames - f0), 64'd1);

    // ---- gapped shift ----
    do_load(33'h0_AAAA_AAAA);
    lat = 0;
    for (int n = 1; n <= 80; n++) begin
      shift = n[0];
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      step();
    end
    shift = 1'b0;
    chk("gap_latency", 64'(lat), 64'd66);
    chk("gap_rx", 64'(rx_last), 64'h0_AAAA_AAAA);
    step();

    // ---- load while busy ----
    f0 = frames;
    do_load(33'h0_1357_9BDF);
    shift = 1'b1;
    repeat (5) step();
    p_in       = 33'h1_FFFF_FFFF;
    load_valid = 1'b1;
    wait_frames(f0 + 1, 100, "busy_f1");
    chk("busy_rx1", 64'(rx_last), 64'h0_1357_9BDF);
    // the held request is taken on the first edge with load_ready high
    @(negedge clk);
    chk("busy_ready_rise", 64'(load_ready), 64'd1);
    step();
    load_valid = 1'b0;
    @(negedge clk);
    chk("busy_reloaded", 64'(busy), 64'd1);
    step();
    wait_frames(f0 + 2, 100, "busy_f2");
    chk("busy_rx2", 64'(rx_last), 64'h1_FFFF_FFFF);
    shift = 1'b0;
    step();

    // ---- reset mid-frame ----
    f0 = frames;
    do_load(33'h1_0000_0001);
    shift = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("mid_count10", 64'(count), 64'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    shift = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_s_out", 64'(s_out), 64'd0);
    repeat (5) step();
    chk("mid_no_done", 64'(done_cnt - d0), 64'd0);
    chk("mid_no_frame", 64'(frames - f0), 64'd0);
    do_load(33'h1_0000_0001);
    shift = 1'b1;
    wait_frames(f0 + 1, 100, "mid_fresh");
    shift = 1'b0;
    chk("mid_fresh_rx", 64'(rx_last), 64'h1_0000_0001);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_33bit.md
Name: piso_33bit

Overview:
- Parallel-in/serial-out transmitter: the sending end of the 33-bit serial link whose receiving end is sipo_33bit.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then drives it LSB-first on s_out, one bit per cycle in which shift is high.
- Driving sipo_33bit from the same shift strobe rebuilds the word in p_out after WIDTH shifts.
- Raises a one-cycle done pulse when the frame is complete.

Parameters:
- WIDTH, 33, word width in bits; supported range 2..64.
- CW, $clog2(WIDTH+1) (6 at default), width of count; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- load_valid  input  1  p_in holds a word to send.
- load_ready  output  1  block can accept a word (high only in IDLE).
- p_in  input  WIDTH  parallel word; sampled only on load handshake.
- shift  input  1  bit strobe; same signal that drives sipo_33bit shift.
- s_out  output  1  serial data; current bit is valid while busy.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after last bit shifted.
- count  output  CW  bits already shifted in the current frame.

Behaviour:
- Reset: synchronous to clk, active-high. Sampled high on an edge forces state=IDLE, shreg=0, count=0, done=0. This gives s_out=0, busy=0, load_ready=1. Reset mid-frame aborts the frame with no done pulse.
- States: IDLE and SHIFT, one-hot or binary encoding.
- Outputs: busy = (state==SHIFT); load_ready = (state==IDLE).
- s_out = shreg[0] in SHIFT, 0 in IDLE. It is a combinational decode of registers only, with no input-to-output path.
- IDLE, load_valid=1: p_in is captured into shreg, count<=0, state goes to SHIFT. The bit p_in[0] appears on s_out in the next cycle.
- IDLE, shift=1: ignored; shreg and count hold.
- SHIFT, shift=1:
  - shreg <= shreg >> 1 with 0 filled at the MSB.
  - count <= count+1.
  - If count==WIDTH-1 (the last bit is leaving): state<=IDLE, count<=WIDTH, done<=1 for the following cycle only.
- SHIFT, shift=0: all state holds; s_out is stable.
- SHIFT, load_valid=1: ignored because load_ready=0. The source must hold valid until ready.
- No same-cycle reload: after the final shift, the next load is accepted at the earliest one cycle later, when load_ready is seen high.
- count stays at WIDTH in IDLE after a frame, stays 0 after reset, and cleared to 0 on load. It never wraps.
- Latency:
  - Load edge to first bit on s_out: 1 cycle.
  - Frame length: exactly WIDTH shift-high edges.
  - done is asserted in the cycle after the final shift edge.
- Link timing: the receiver samples s_out on the same clk edge that advances shreg. Each bit is therefore valid for the whole cycle before a shift edge.

Decomposition:
- Shared package piso_pkg:
  - state enum {IDLE, SHIFT}.
  - Localparam DEFAULT_WIDTH=33.
  - Function cw_of(width) returning $clog2(width+1).
- One natural sub-module: dff_sr, a parameterized WIDTH register with synchronous active-high reset and enable. It is instantiated for shreg, count, state and done.
- All next-state logic lives in piso_33bit.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: s_out=0, busy=0, load_ready=1, count=0, done=0. Shift=1 pulses while idle leave count=0.
- Loopback, continuous shift:
  - Stimulus: load p_in=33'h1_2345_6789, then shift=1 for 33 cycles. Drive sipo_33bit with its rst_n tied to ~rst.
  - Required: sipo p_out==33'h1_2345_6789 after the 33rd edge, count=33, one done pulse, load_ready=1 the next cycle.
- Gapped shift:
  - Stimulus: p_in=33'h0_AAAA_AAAA, shift toggled 1/0 every cycle.
  - Required: s_out holds during shift=0 cycles. Bit sequence is 0,1,0,1,... LSB-first. done appears after 66 cycles.
- Load while busy:
  - Stimulus: mid-frame, assert load_valid with p_in=33'h1_FFFF_FFFF.
  - Required: load ignored and the original word is completed intact. The new word is accepted only after load_ready rises, then shifts out all ones.
- Reset mid-frame:
  - Stimulus: assert rst after 10 shifts of 33'h1_0000_0001.
  - Required: next cycle busy=0, count=0, s_out=0, no done pulse. A fresh load then completes normally.
